// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//   IFU fetch-control stage. Owns the architectural PC and issues one
//   instruction read at a time on an AXI-lite-style AR/R channel. The fetched
//   {inst, pc} pair is offered to decode over a valid/ready handshake. On each
//   handoff the next PC is taken from the PC-select mux, which is fed by pc_o.
//   A flush redirects fetch. A read that is already in flight is allowed to
//   complete, and its data is dropped.
//
// Ports
//   clk, rst                  clock (rising edge); async reset, active-low
//   next_pc_i                 next PC from the PC-select mux
//   flush_i, flush_pc_i       redirect pulse and its target
//   pc_o                      architectural PC register
//   araddr_o/arvalid_o/arready_i                read address channel
//   rdata_i/rresp_i/rvalid_i/rready_o           read data channel
//   inst_o/inst_pc_o/inst_valid_o/inst_ready_i  decode handshake
//   fetch_err_o               inst_o is a bus error or a misaligned fetch
// -----------------------------------------------------------------------------
module ifu_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] next_pc_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic              fetch_err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_HOLD
   } state_t;

   state_t state;
   logic   kill;   // the outstanding read belongs to a flushed path

   // A new fetch is launched from IDLE, after a killed beat drains, on a
   // decode handoff, or on a flush in HOLD. Every launch goes through the
   // same misalignment test in the register block below.
   logic              launch;
   logic [ADDR_W-1:0] launch_addr;
   logic              launch_misaligned;

   // NOTE: every combinational output gets a default before the case, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      launch      = 1'b0;
      launch_addr = pc_o;
      case (state)
         S_IDLE: begin
            launch      = 1'b1;
            launch_addr = flush_i ? flush_pc_i : pc_o;
         end
         S_RESP: begin
            // The beat is dropped when a flush arrives with it or was already
            // pending. pc_o holds the most recent flush target.
            if (rvalid_i && (kill || flush_i)) begin
               launch      = 1'b1;
               launch_addr = flush_i ? flush_pc_i : pc_o;
            end
         end
         S_HOLD: begin
            if (flush_i) begin
               launch      = 1'b1;
               launch_addr = flush_pc_i;
            end else if (inst_ready_i) begin
               launch      = 1'b1;
               launch_addr = next_pc_i;
            end
         end
         default: ;
      endcase
   end

   assign launch_misaligned = |launch_addr[1:0];

   // NOTE: sequential state uses non-blocking assignments only. Every read
   // below sees the pre-edge value. A later assignment in this block overrides
   // an earlier one, and the launch section at the end relies on that.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         pc_o         <= RESET_PC;
         araddr_o     <= '0;
         arvalid_o    <= 1'b0;
         rready_o     <= 1'b0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         inst_valid_o <= 1'b0;
         fetch_err_o  <= 1'b0;
         kill         <= 1'b0;
      end else begin
         // A flush always wins the PC. Otherwise the PC advances only on a
         // decode handoff.
         if (flush_i) begin
            pc_o <= flush_pc_i;
         end else if (state == S_HOLD && inst_ready_i) begin
            pc_o <= next_pc_i;
         end

         case (state)
            S_REQ: begin
               // A presented request cannot be retracted. A flush only marks
               // its response for disposal.
               if (flush_i) begin
                  kill <= 1'b1;
               end
               if (arready_i) begin
                  arvalid_o <= 1'b0;
                  rready_o  <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rvalid_i) begin
                  rready_o <= 1'b0;
                  if (!kill && !flush_i) begin
                     inst_o       <= rdata_i;
                     inst_pc_o    <= araddr_o;
                     fetch_err_o  <= (rresp_i != 2'b00);
                     inst_valid_o <= 1'b1;
                     state        <= S_HOLD;
                  end
               end else if (flush_i) begin
                  kill <= 1'b1;
               end
            end
            default: ;
         endcase

         if (launch) begin
            araddr_o <= launch_addr;
            kill     <= 1'b0;
            if (launch_misaligned) begin
               // No bus request is issued. The error is reported in place of
               // an instruction.
               arvalid_o    <= 1'b0;
               inst_o       <= '0;
               inst_pc_o    <= launch_addr;
               fetch_err_o  <= 1'b1;
               inst_valid_o <= 1'b1;
               state        <= S_HOLD;
            end else begin
               arvalid_o    <= 1'b1;
               inst_valid_o <= 1'b0;
               state        <= S_REQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch
//   Self-checking bench for ifu_fetch. A responder process models the memory.
//   It has an optional AR stall and a fixed read latency. The model of the
//   fetch unit is architectural. It tracks the PC from reset, flushes and
//   decode handoffs. The compare process then requires that:
//     - any instruction offered to decode is the one at that PC;
//     - the AR channel obeys its protocol;
//     - the held instruction stays put while decode stalls.
//   Directed steps pin latencies and specific values with literals.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam logic [31:0] BEEF_ADDR = 32'h8000_0010;
   localparam logic [31:0] ERR_ADDR  = 32'h8000_0104;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_pc_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic [31:0] pc_o;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i;
   logic        rready_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic        fetch_err_o;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // Memory responder controls
   bit ar_en   = 1'b1;
   int r_delay = 1;

   always #5 clk = ~clk;

   // PC-select mux: sequential fetch.
   assign next_pc_i = pc_o + 32'd4;

   ifu_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .next_pc_i    (next_pc_i),
      .flush_i      (flush_i),
      .flush_pc_i   (flush_pc_i),
      .pc_o         (pc_o),
      .araddr_o     (araddr_o),
      .arvalid_o    (arvalid_o),
      .arready_i    (arready_i),
      .rdata_i      (rdata_i),
      .rresp_i      (rresp_i),
      .rvalid_i     (rvalid_i),
      .rready_o     (rready_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .fetch_err_o  (fetch_err_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == BEEF_ADDR) return 32'hDEAD_BEEF;
      if (a == ERR_ADDR)  return 32'h0000_0013;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] exp_inst(input logic [31:0] a);
      return (a[1:0] != 2'b00) ? 32'h0 : mem_data(a);
   endfunction

   function automatic logic exp_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a == ERR_ADDR);
   endfunction

   // ---------------------------------------------------------------------------
   // Memory responder. It runs just after each rising edge, when DUT outputs
   // are settled. It decides the inputs for the coming edge and records the
   // handshakes that edge will complete.
   // ---------------------------------------------------------------------------
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   initial begin
      arready_i = 1'b0;
      rvalid_i  = 1'b0;
      rdata_i   = '0;
      rresp_i   = 2'b00;
      pend      = 1'b0;
      pend_addr = '0;
      pend_cnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            pend      = 1'b0;
            rvalid_i  = 1'b0;
            arready_i = 1'b0;
         end else begin
            rvalid_i = 1'b0;
            if (pend) begin
               if (pend_cnt > 0) begin
                  pend_cnt--;
               end else begin
                  rvalid_i = 1'b1;
                  rdata_i  = mem_data(pend_addr);
                  rresp_i  = (pend_addr == ERR_ADDR) ? 2'b10 : 2'b00;
                  if (rready_o) pend = 1'b0;
               end
            end
            arready_i = ar_en;
            if (arvalid_o && arready_i) begin
               pend      = 1'b1;
               pend_addr = araddr_o;
               pend_cnt  = r_delay;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Architectural model and per-cycle compare. This runs on the falling edge,
   // when inputs and outputs are both stable.
   // ---------------------------------------------------------------------------
   logic [31:0] m_pc = RESET_PC;
   bit          have_prev = 1'b0;
   logic        p_arvalid, p_arready, p_ivalid, p_iready, p_flush;
   logic [31:0] p_araddr;
   int          idle_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         check("rst_pc",        pc_o,         RESET_PC);
         check("rst_araddr",    araddr_o,     32'h0);
         check("rst_arvalid",   arvalid_o,    1'b0);
         check("rst_rready",    rready_o,     1'b0);
         check("rst_inst",      inst_o,       32'h0);
         check("rst_inst_pc",   inst_pc_o,    32'h0);
         check("rst_inst_valid", inst_valid_o, 1'b0);
         check("rst_fetch_err", fetch_err_o,  1'b0);
         have_prev = 1'b0;
         idle_cnt  = 0;
      end else begin
         check("pc", pc_o, m_pc);
         if (inst_valid_o) begin
            check("inst_pc",   inst_pc_o,   m_pc);
            check("inst",      inst_o,      exp_inst(m_pc));
            check("fetch_err", fetch_err_o, exp_err(m_pc));
            idle_cnt = 0;
         end else begin
            idle_cnt++;
         end
         if (idle_cnt > 40) begin
            check("progress_cycles", idle_cnt, 0);
            idle_cnt = 0;
         end
         if (arvalid_o) check("ar_aligned", araddr_o[1:0], 2'b00);
         if (have_prev && p_arvalid && !p_arready) begin
            check("ar_hold_valid", arvalid_o, 1'b1);
            check("ar_hold_addr",  araddr_o,  p_araddr);
         end
         if (have_prev && p_ivalid && !p_iready && !p_flush) begin
            check("inst_hold_valid", inst_valid_o, 1'b1);
         end
         have_prev = 1'b1;
      end
      p_arvalid = arvalid_o;
      p_arready = arready_i;
      p_araddr  = araddr_o;
      p_ivalid  = inst_valid_o;
      p_iready  = inst_ready_i;
      p_flush   = flush_i;
      // Advance the PC through the upcoming edge.
      if (!rst)                             m_pc = RESET_PC;
      else if (flush_i)                     m_pc = flush_pc_i;
      else if (inst_valid_o && inst_ready_i) m_pc = next_pc_i;
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus. Inputs change 2 time units after the rising edge.
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #2;
      cyc_n++;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!inst_valid_o && n < 40) begin
         cyc();
         n++;
      end
      check({name, "_valid_seen"}, inst_valid_o, 1'b1);
   endtask

   task automatic wait_resp(input string name, input bit need_rvalid);
      int n = 0;
      while (!(rready_o && (rvalid_i || !need_rvalid)) && n < 40) begin
         cyc();
         n++;
      end
      check({name, "_resp_seen"}, rready_o && (rvalid_i || !need_rvalid), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] seq_pc [3];
      int          at [3];
      int          n;

      seq_pc[0] = 32'h8000_0000;
      seq_pc[1] = 32'h8000_0004;
      seq_pc[2] = 32'h8000_0008;

      rst          = 1'b0;
      flush_i      = 1'b0;
      flush_pc_i   = '0;
      inst_ready_i = 1'b1;

      // 1: reset for three cycles, then release.
      repeat (3) cyc();
      rst = 1'b1;
      check("t1_pc",         pc_o,      32'h8000_0000);
      check("t1_arvalid_c1", arvalid_o, 1'b0);
      cyc();
      check("t1_arvalid_c2", arvalid_o, 1'b1);
      check("t1_araddr",     araddr_o,  32'h8000_0000);

      // 2: sequential fetch with zero-wait AR, decode always ready.
      for (int i = 0; i < 3; i++) begin
         wait_valid("t2");
         at[i] = cyc_n;
         check("t2_inst_pc", inst_pc_o, seq_pc[i]);
         if (i == 2) ar_en = 1'b0;
         cyc();
      end
      check("t2_spacing_a", at[1] - at[0], 4);
      check("t2_spacing_b", at[2] - at[1], 4);

      // 3: AR stalled, then decode stalled.
      for (int i = 0; i < 5; i++) begin
         check("t3_arvalid", arvalid_o, 1'b1);
         check("t3_araddr",  araddr_o,  32'h8000_000C);
         cyc();
      end
      ar_en        = 1'b1;
      inst_ready_i = 1'b0;
      wait_valid("t3");
      for (int i = 0; i < 4; i++) begin
         check("t3_inst",       inst_o,       32'h000C_FFF3);
         check("t3_inst_pc",    inst_pc_o,    32'h8000_000C);
         check("t3_inst_valid", inst_valid_o, 1'b1);
         if (i < 3) cyc();
      end
      inst_ready_i = 1'b1;
      cyc();

      // 4: flush during RESP. The 0xDEADBEEF beat must be dropped.
      wait_resp("t4", 1'b0);
      flush_i    = 1'b1;
      flush_pc_i = 32'h8000_0100;
      cyc();
      flush_i = 1'b0;
      n = 0;
      while (!arvalid_o && n < 20) begin
         check("t4_no_inst", inst_valid_o, 1'b0);
         cyc();
         n++;
      end
      check("t4_arvalid", arvalid_o, 1'b1);
      check("t4_araddr",  araddr_o,  32'h8000_0100);
      wait_valid("t4");
      check("t4_inst_pc", inst_pc_o, 32'h8000_0100);
      cyc();

      // 5: the bus error response is still delivered, qualified by fetch_err.
      wait_valid("t5");
      check("t5_fetch_err", fetch_err_o, 1'b1);
      check("t5_inst",      inst_o,      32'h0000_0013);
      check("t5_inst_pc",   inst_pc_o,   32'h8000_0104);
      cyc();

      // Flush in the same cycle as the rvalid beat.
      wait_resp("t4b", 1'b1);
      flush_i      = 1'b1;
      flush_pc_i   = 32'h8000_0200;
      inst_ready_i = 1'b0;
      cyc();
      flush_i = 1'b0;
      check("t4b_arvalid",    arvalid_o,    1'b1);
      check("t4b_araddr",     araddr_o,     32'h8000_0200);
      check("t4b_inst_valid", inst_valid_o, 1'b0);
      check("t4b_pc",         pc_o,         32'h8000_0200);

      // 6: misaligned flush target from HOLD. No bus request; error reported.
      wait_valid("t6");
      check("t6_hold_pc", inst_pc_o, 32'h8000_0200);
      flush_i    = 1'b1;
      flush_pc_i = 32'h8000_0002;
      cyc();
      flush_i = 1'b0;
      check("t6_inst_valid", inst_valid_o, 1'b1);
      check("t6_fetch_err",  fetch_err_o,  1'b1);
      check("t6_inst_pc",    inst_pc_o,    32'h8000_0002);
      check("t6_inst",       inst_o,       32'h0);
      for (int i = 0; i < 3; i++) begin
         check("t6_no_arvalid", arvalid_o, 1'b0);
         cyc();
      end
      // Flush and handoff together: the flush target is fetched.
      flush_i      = 1'b1;
      flush_pc_i   = 32'h8000_0300;
      inst_ready_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      check("t6b_pc",         pc_o,         32'h8000_0300);
      check("t6b_arvalid",    arvalid_o,    1'b1);
      check("t6b_araddr",     araddr_o,     32'h8000_0300);
      check("t6b_inst_valid", inst_valid_o, 1'b0);
      wait_valid("t6b");
      check("t6b_inst_pc", inst_pc_o, 32'h8000_0300);
      repeat (4) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
